// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU over valid/ready, with a tagged response channel.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
//
// state | meaning
// IDLE  | grant offered to the arbitration winner, operands latched on handshake
// EXEC  | ALU inputs stable, result captured at the edge
// RESP  | response held until the consumer takes it
module alu_share_arbiter #(
    parameter int N    = 64,
    parameter int CTLW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [N-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    input  logic [CTLW-1:0] req0_ctl,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [N-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    input  logic [CTLW-1:0] req1_ctl,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [N-1:0]    resp_result,
    output logic            resp_zero,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [CTLW-1:0] alu_ctl,
    input  logic [N-1:0]    alu_result,
    input  logic            alu_zero,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic            r_id;
    logic [N-1:0]    r_alu_a;
    logic [N-1:0]    r_alu_b;
    logic [CTLW-1:0] r_alu_ctl;
    logic            r_resp_id;
    logic [N-1:0]    r_resp_result;
    logic            r_resp_zero;
    logic            w_gnt_valid;
    logic            w_gnt_id;
    logic            w_hs;

    always_comb begin
        w_gnt_valid = req0_valid | req1_valid;
        w_gnt_id    = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w_gnt_id = 1'b0;
`else
            w_gnt_id = ~r_last_grant;
`endif
        end else if (req1_valid) begin
            w_gnt_id = 1'b1;
        end
    end

    assign w_hs = (r_state == IDLE) && w_gnt_valid;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_gnt_valid & ~w_gnt_id;
                req1_ready = w_gnt_valid &  w_gnt_id;
                if (w_gnt_valid) w_state_nxt = EXEC;
            end
            EXEC: w_state_nxt = RESP;
            RESP: if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands are sampled only in the handshake cycle; the response fields keep their last values after delivery.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_id          <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctl     <= '0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
        end else if (w_hs) begin
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_alu_a      <= w_gnt_id ? req1_a   : req0_a;
            r_alu_b      <= w_gnt_id ? req1_b   : req0_b;
            r_alu_ctl    <= w_gnt_id ? req1_ctl : req0_ctl;
        end else if (r_state == EXEC) begin
            r_resp_result <= alu_result;
            r_resp_zero   <= alu_zero;
            r_resp_id     <= r_id;
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctl     = r_alu_ctl;
    assign resp_valid  = (r_state == RESP);
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU attached.
// Expected grant order follows ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_share_arbiter;
    localparam int N    = 64;
    localparam int CTLW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req0_ready;
    logic [N-1:0]    req0_a, req0_b;
    logic [CTLW-1:0] req0_ctl;
    logic            req1_valid, req1_ready;
    logic [N-1:0]    req1_a, req1_b;
    logic [CTLW-1:0] req1_ctl;
    logic            resp_valid, resp_ready, resp_id, resp_zero;
    logic [N-1:0]    resp_result;
    logic [N-1:0]    alu_a, alu_b, alu_result;
    logic [CTLW-1:0] alu_ctl;
    logic            alu_zero;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(N), .CTLW(CTLW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    always_comb begin
        case (alu_ctl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge in IDLE with requests already driven; returns at the negedge back in IDLE.
    task automatic run_op(input logic exp_id, input logic [N-1:0] exp_res, input logic exp_zero, input string tag);
        #1;
        chk({tag, "_rdy0"}, N'(req0_ready), N'(!exp_id));
        chk({tag, "_rdy1"}, N'(req1_ready), N'(exp_id));
        @(negedge clk);
        chk({tag, "_exec_busy"}, N'(busy), 1);
        chk({tag, "_exec_rdy"}, N'(req0_ready | req1_ready), 0);
        chk({tag, "_exec_rv"}, N'(resp_valid), 0);
        @(negedge clk);
        chk({tag, "_rv"}, N'(resp_valid), 1);
        chk({tag, "_id"}, N'(resp_id), N'(exp_id));
        chk({tag, "_res"}, resp_result, exp_res);
        chk({tag, "_zero"}, N'(resp_zero), N'(exp_zero));
        @(negedge clk);
        chk({tag, "_done_rv"}, N'(resp_valid), 0);
    endtask

    initial begin
        logic exp_id;
        reset = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctl = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", N'(busy), 0);
        chk("rst_rv", N'(resp_valid), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctl", N'(alu_ctl), 0);
        chk("rst_resp_res", resp_result, 0);
        chk("rst_resp_id", N'(resp_id), 0);
        reset = 1'b0;

        // Single request; operands changed after the handshake must not matter.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 64'd239; req0_b = 64'd26; req0_ctl = 4'b0010;
        #1;
        chk("single_rdy0", N'(req0_ready), 1);
        chk("single_rdy1", N'(req1_ready), 0);
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 64'd5000; req0_ctl = 4'b0110;
        chk("single_exec_busy", N'(busy), 1);
        chk("single_alu_a", alu_a, 64'd239);
        chk("single_exec_rv", N'(resp_valid), 0);
        @(negedge clk);
        chk("single_rv", N'(resp_valid), 1);
        chk("single_res", resp_result, 64'd265);
        chk("single_zero", N'(resp_zero), 0);
        chk("single_id", N'(resp_id), 0);
        @(negedge clk);
        chk("single_idle_busy", N'(busy), 0);
        chk("single_idle_rv", N'(resp_valid), 0);
        chk("single_hold_res", resp_result, 64'd265);

        // Both valid straight out of reset: req0 first.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd239; req0_b = 64'd26; req0_ctl = 4'b0000;
        req1_valid = 1'b1; req1_a = -64'd98; req1_b = -64'd407; req1_ctl = 4'b0001;
        run_op(1'b0, 64'd10, 1'b0, "both_first");
        req0_valid = 1'b0;
        run_op(1'b1, -64'd1, 1'b0, "both_second");

        // Fairness: both held valid; last grant was 1 so req0 leads.
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_ctl = 4'b0010;
        req1_valid = 1'b1; req1_a = 64'd5; req1_b = 64'd3; req1_ctl = 4'b0110;
        for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = i[0];
`endif
            run_op(exp_id, exp_id ? 64'd2 : 64'd3, 1'b0, $sformatf("rr%0d", i));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure on a req1 subtraction; req0 waits meanwhile.
        req1_valid = 1'b1; req1_a = 64'd930; req1_b = -64'd33; req1_ctl = 4'b0110;
        resp_ready = 1'b0;
        #1;
        chk("bp_rdy1", N'(req1_ready), 1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd26; req0_b = 64'd26; req0_ctl = 4'b0110;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rv%0d", i), N'(resp_valid), 1);
            chk($sformatf("bp_res%0d", i), resp_result, 64'd963);
            chk($sformatf("bp_id%0d", i), N'(resp_id), 1);
            chk($sformatf("bp_rdy%0d", i), N'(req0_ready | req1_ready), 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_busy", N'(busy), 0);
        chk("bp_release_rv", N'(resp_valid), 0);

        // Zero flag with req0 already pending.
        run_op(1'b0, 64'd0, 1'b1, "zero");
        req0_valid = 1'b0;

        // Reset while executing aborts the operation.
        req0_valid = 1'b1; req0_a = 64'd930; req0_b = -64'd33; req0_ctl = 4'b0010;
        #1;
        chk("abort_rdy0", N'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("abort_exec_busy", N'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", N'(busy), 0);
        chk("abort_alu_ctl", N'(alu_ctl), 0);
        chk("abort_rv", N'(resp_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", i), N'(resp_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
